// File: rtl/adder_accumulator.sv
// Sums each group of LEN consecutive valid adder results into a wider total
// and presents it on a one-entry valid/ready buffer; unbufferable totals set a sticky drop flag.
`timescale 1ns/1ps
module adder_accumulator #(
  parameter int BITS = 8,
  parameter int LEN  = 4,
  localparam int ACC_BITS = BITS + $clog2(LEN),
  localparam int CNT_BITS = $clog2(LEN + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                valid_in,
  input  logic [BITS-1:0]     data_in,
  input  logic                clear,
  output logic [ACC_BITS-1:0] sum_out,
  output logic                sum_valid,
  input  logic                sum_ready,
  output logic [CNT_BITS-1:0] cnt,
  output logic                drop
);

  logic [ACC_BITS-1:0] acc;
  logic [ACC_BITS-1:0] total;
  logic                take;
  logic                last;
  logic                complete;
  logic                handshake;
  logic                buf_free;

  always_comb begin
    take      = valid_in && !clear;
    last      = (cnt == CNT_BITS'(LEN - 1));
    complete  = take && last;
    total     = acc + ACC_BITS'(data_in);
    handshake = sum_valid && sum_ready;
    // The buffer can take a new total if it is empty or drains on this edge.
    buf_free  = !sum_valid || sum_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
    end else if (clear || complete) begin
      acc <= '0;
      cnt <= '0;
    end else if (valid_in) begin
      acc <= total;
      cnt <= cnt + CNT_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_out   <= '0;
      sum_valid <= 1'b0;
      drop      <= 1'b0;
    end else if (complete) begin
      if (buf_free) begin
        sum_out   <= total;
        sum_valid <= 1'b1;
      end else begin
        drop <= 1'b1;
      end
    end else if (handshake) begin
      sum_valid <= 1'b0;
    end
  end

endmodule
